shape_compositor: RTL and testbench

SHAPE_COMPOSITOR -- requirements
Module: shape_compositor

---
 rtl/shape_compositor.sv | 201 ++++++++++++++++++++
 tb/tb_shape_compositor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_compositor.sv
// shape_compositor
//   Double-buffered object table plus a 3-stage pixel classifier. For each
//   queried screen pixel it reports which kind of object covers it and where
//   that pixel lands in a down-scaled framebuffer.
//
//   Build option: define SHAPE_COMPOSITOR_OVERLAP_EN to report pixels hit by
//   two or more slots as color 11. Without it, the lowest-indexed hit wins and
//   11 is never produced.
//
//   Ports
//     clk_in, rst_in    clock, synchronous active-high reset
//     obj_we, obj_idx   write strobe and slot index into the shadow bank
//     obj_kind          00 none, 01 circle, 10 filled rect, 11 rect outline
//     obj_static        1 static object, 0 movable object
//     obj_x1/y1/x2/y2   shape coordinates (circle: centre x1,y1, radius x2)
//     swap_in           pulse: shadow and active banks exchange on the next cycle
//     valid_in          pixel query present (hcount_in, vcount_in)
//     color_bits        00 background, 01 static, 10 movable, 11 overlap
//     write_address     framebuffer address of the pixel
//     valid_out         color_bits / write_address valid this cycle
//
//   Handshake: valid_in / valid_out form a valid-only stream. There is no
//   ready; one pixel is accepted per cycle, and each accepted pixel appears
//   exactly 3 cycles later. Dropped pixels (off the scale grid) produce no
//   valid_out.
module shape_compositor #(
  parameter int NUM_OBJS    = 8,
  parameter int FB_WIDTH    = 640,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        obj_we,
  input  logic [$clog2(NUM_OBJS)-1:0] obj_idx,
  input  logic [1:0]                  obj_kind,
  input  logic                        obj_static,
  input  logic [10:0]                 obj_x1,
  input  logic [10:0]                 obj_x2,
  input  logic [9:0]                  obj_y1,
  input  logic [9:0]                  obj_y2,
  input  logic                        swap_in,
  input  logic                        valid_in,
  input  logic [10:0]                 hcount_in,
  input  logic [9:0]                  vcount_in,
  output logic [1:0]                  color_bits,
  output logic [18:0]                 write_address,
  output logic                        valid_out
);

  typedef struct packed {
    logic [1:0]  kind;
    logic        is_static;
    logic [10:0] x1;
    logic [9:0]  y1;
    logic [10:0] x2;
    logic [9:0]  y2;
  } obj_t;

  localparam logic [10:0] H_MASK = 11'((1 << SCALE_SHIFT) - 1);
  localparam logic [9:0]  V_MASK = 10'((1 << SCALE_SHIFT) - 1);

  // ---------------- object banks ----------------
  obj_t bank0 [NUM_OBJS];
  obj_t bank1 [NUM_OBJS];
  logic active_sel;  // 0: bank0 active, bank1 shadow
  obj_t wr_obj;

  assign wr_obj = {obj_kind, obj_static, obj_x1, obj_y1, obj_x2, obj_y2};

  // The write targets the shadow bank as seen before the swap takes effect,
  // so a write coincident with swap_in lands in the bank that becomes active.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_sel <= 1'b0;
      for (int i = 0; i < NUM_OBJS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      if (obj_we) begin
        if (active_sel) bank0[obj_idx] <= wr_obj;
        else            bank1[obj_idx] <= wr_obj;
      end
      if (swap_in) active_sel <= ~active_sel;
    end
  end

  // ---------------- stage 0: capture pixel + active table ----------------
  obj_t        s0_obj [NUM_OBJS];
  logic [10:0] s0_h;
  logic [9:0]  s0_v;
  logic        s0_valid;
  logic        on_grid;

  assign on_grid = ((hcount_in & H_MASK) == '0) && ((vcount_in & V_MASK) == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) s0_valid <= 1'b0;
    else        s0_valid <= valid_in && on_grid;
  end

  // Snapshotting the whole table keeps in-flight pixels immune to swaps.
  always_ff @(posedge clk_in) begin
    if (valid_in) begin
      s0_h <= hcount_in;
      s0_v <= vcount_in;
      for (int i = 0; i < NUM_OBJS; i++) begin
        s0_obj[i] <= active_sel ? bank1[i] : bank0[i];
      end
    end
  end

  // ---------------- stage 1: per-slot geometry ----------------
  logic [NUM_OBJS-1:0] slot_hit;
  logic [NUM_OBJS-1:0] slot_static;
  logic [18:0]         addr_c;

  for (genvar g = 0; g < NUM_OBJS; g++) begin : g_slot
    logic [10:0] dx;
    logic [9:0]  dy;
    logic [21:0] dx2, dy2, r2;
    logic [22:0] dist2;
    logic        in_rect, on_edge;

    assign dx    = (s0_h >= s0_obj[g].x1) ? s0_h - s0_obj[g].x1 : s0_obj[g].x1 - s0_h;
    assign dy    = (s0_v >= s0_obj[g].y1) ? s0_v - s0_obj[g].y1 : s0_obj[g].y1 - s0_v;
    assign dx2   = 22'(dx) * 22'(dx);
    assign dy2   = 22'(dy) * 22'(dy);
    assign r2    = 22'(s0_obj[g].x2) * 22'(s0_obj[g].x2);
    assign dist2 = {1'b0, dx2} + {1'b0, dy2};

    // An inverted rect (x1>x2 or y1>y2) can never satisfy both bounds.
    assign in_rect = (s0_h >= s0_obj[g].x1) && (s0_h <= s0_obj[g].x2) &&
                     (s0_v >= s0_obj[g].y1) && (s0_v <= s0_obj[g].y2);
    assign on_edge = (s0_h == s0_obj[g].x1) || (s0_h == s0_obj[g].x2) ||
                     (s0_v == s0_obj[g].y1) || (s0_v == s0_obj[g].y2);

    assign slot_hit[g] = (s0_obj[g].kind == 2'b01) ? (dist2 <= {1'b0, r2}) :
                         (s0_obj[g].kind == 2'b10) ? in_rect :
                         (s0_obj[g].kind == 2'b11) ? (in_rect && on_edge) : 1'b0;
    assign slot_static[g] = s0_obj[g].is_static;
  end

  assign addr_c = 19'(s0_h >> SCALE_SHIFT) + 19'(FB_WIDTH) * 19'(s0_v >> SCALE_SHIFT);

  logic                s1_valid;
  logic [NUM_OBJS-1:0] s1_hit;
  logic [NUM_OBJS-1:0] s1_static;
  logic [18:0]         s1_addr;

  always_ff @(posedge clk_in) begin
    if (rst_in) s1_valid <= 1'b0;
    else        s1_valid <= s0_valid;
  end

  always_ff @(posedge clk_in) begin
    if (s0_valid) begin
      s1_hit    <= slot_hit;
      s1_static <= slot_static;
      s1_addr   <= addr_c;
    end
  end

  // ---------------- stage 2: priority select ----------------
  logic [1:0] sel_color;
  logic       found;

`ifdef SHAPE_COMPOSITOR_OVERLAP_EN
  localparam logic [NUM_OBJS-1:0] ONE = 1;
`endif

  always_comb begin
    sel_color = 2'b00;
    found     = 1'b0;
    for (int i = 0; i < NUM_OBJS; i++) begin
      if (!found && s1_hit[i]) begin
        found     = 1'b1;
        sel_color = s1_static[i] ? 2'b01 : 2'b10;
      end
    end
`ifdef SHAPE_COMPOSITOR_OVERLAP_EN
    // Clearing the lowest set bit leaves something only when 2+ slots hit.
    if ((s1_hit & (s1_hit - ONE)) != '0) sel_color = 2'b11;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out     <= 1'b0;
      color_bits    <= 2'b00;
      write_address <= '0;
    end else begin
      valid_out <= s1_valid;
      if (s1_valid) begin
        color_bits    <= sel_color;
        write_address <= s1_addr;
      end
    end
  end

endmodule

// File: tb/tb_shape_compositor.sv
// tb_shape_compositor
//   Directed scenarios followed by a randomized phase, all checked every cycle
//   against a behavioural model of the compositor kept in this file.
module tb_shape_compositor;
  localparam int NUM_OBJS    = 8;
  localparam int FB_WIDTH    = 640;
  localparam int SCALE_SHIFT = 1;
  localparam int IDX_W       = $clog2(NUM_OBJS);

  // ---------------- clock / reset / DUT ----------------
  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              obj_we = 1'b0;
  logic [IDX_W-1:0]  obj_idx = '0;
  logic [1:0]        obj_kind = '0;
  logic              obj_static = 1'b0;
  logic [10:0]       obj_x1 = '0, obj_x2 = '0;
  logic [9:0]        obj_y1 = '0, obj_y2 = '0;
  logic              swap_in = 1'b0;
  logic              valid_in = 1'b0;
  logic [10:0]       hcount_in = '0;
  logic [9:0]        vcount_in = '0;
  logic [1:0]        color_bits;
  logic [18:0]       write_address;
  logic              valid_out;

  always #5 clk_in = ~clk_in;

  shape_compositor #(
    .NUM_OBJS(NUM_OBJS), .FB_WIDTH(FB_WIDTH), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .obj_we(obj_we), .obj_idx(obj_idx),
    .obj_kind(obj_kind), .obj_static(obj_static),
    .obj_x1(obj_x1), .obj_x2(obj_x2), .obj_y1(obj_y1), .obj_y2(obj_y2),
    .swap_in(swap_in), .valid_in(valid_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .color_bits(color_bits), .write_address(write_address), .valid_out(valid_out)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int kind;
    int st;
    int x1, y1, x2, y2;
  } mobj_t;

  mobj_t tbl [2][NUM_OBJS];
  int    act = 0;

  // Expected output per accepted edge: {valid, color[1:0], addr[18:0]}
  logic [21:0] exp_q[$];
  logic        exp_valid = 1'b0;
  logic [1:0]  exp_color = 2'b00;
  logic [18:0] exp_addr  = '0;

  int n_vec = 0;
  int n_err = 0;

  function automatic bit shape_hit(mobj_t o, int h, int v);
    bit inside_box;
    inside_box = (h >= o.x1) && (h <= o.x2) && (v >= o.y1) && (v <= o.y2);
    case (o.kind)
      1: return ((h - o.x1) * (h - o.x1) + (v - o.y1) * (v - o.y1)) <= o.x2 * o.x2;
      2: return inside_box;
      3: return inside_box && (h == o.x1 || h == o.x2 || v == o.y1 || v == o.y2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [21:0] model_pixel(int h, int v);
    int mask, hits, first, color, addr;
    logic [1:0]  c2;
    logic [18:0] a19;
    mask = (1 << SCALE_SHIFT) - 1;
    if ((h & mask) != 0 || (v & mask) != 0) return 22'd0;
    hits  = 0;
    first = -1;
    for (int i = 0; i < NUM_OBJS; i++) begin
      if (shape_hit(tbl[act][i], h, v)) begin
        hits++;
        if (first < 0) first = i;
      end
    end
    color = (first < 0) ? 0 : (tbl[act][first].st != 0 ? 1 : 2);
`ifdef SHAPE_COMPOSITOR_OVERLAP_EN
    if (hits >= 2) color = 3;
`endif
    addr = ((h >> SCALE_SHIFT) + FB_WIDTH * (v >> SCALE_SHIFT)) % (1 << 19);
    c2  = color[1:0];
    a19 = addr[18:0];
    return {1'b1, c2, a19};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_obj(input int idx, input int kind, input int st,
                         input int x1, input int y1, input int x2, input int y2);
    obj_we     = 1'b1;
    obj_idx    = idx[IDX_W-1:0];
    obj_kind   = kind[1:0];
    obj_static = st[0];
    obj_x1     = x1[10:0];
    obj_y1     = y1[9:0];
    obj_x2     = x2[10:0];
    obj_y2     = y2[9:0];
  endtask

  task automatic set_px(input int h, input int v);
    valid_in  = 1'b1;
    hcount_in = h[10:0];
    vcount_in = v[9:0];
  endtask

  // One clock: predict from the inputs presented, advance, then compare.
  task automatic tick(input string tag);
    bit          r, we, sw;
    int          idx;
    mobj_t       wobj;
    logic [21:0] pix, outr;
    r   = rst_in;
    we  = obj_we;
    sw  = swap_in;
    idx = int'(obj_idx);
    wobj.kind = int'(obj_kind); wobj.st = int'(obj_static);
    wobj.x1 = int'(obj_x1); wobj.y1 = int'(obj_y1);
    wobj.x2 = int'(obj_x2); wobj.y2 = int'(obj_y2);
    pix = (valid_in && !r) ? model_pixel(int'(hcount_in), int'(vcount_in)) : 22'd0;

    @(posedge clk_in);
    #1;

    if (r) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_OBJS; i++)
          tbl[b][i] = '{kind: 0, st: 0, x1: 0, y1: 0, x2: 0, y2: 0};
      act = 0;
      exp_q.delete();
      exp_q.push_back(22'd0);
      exp_q.push_back(22'd0);
      exp_valid = 1'b0;
      exp_color = 2'b00;
      exp_addr  = '0;
    end else begin
      if (we) tbl[act ^ 1][idx] = wobj;
      if (sw) act ^= 1;
      exp_q.push_back(pix);
      outr = exp_q.pop_front();
      exp_valid = outr[21];
      if (outr[21]) begin
        exp_color = outr[20:19];
        exp_addr  = outr[18:0];
      end
    end

    n_vec++;
    assert (valid_out === exp_valid) else begin
      n_err++;
      $error("FAIL %s valid_out: got %0b expected %0b", tag, valid_out, exp_valid);
    end
    n_vec++;
    assert (color_bits === exp_color) else begin
      n_err++;
      $error("FAIL %s color_bits: got %0b expected %0b", tag, color_bits, exp_color);
    end
    n_vec++;
    assert (write_address === exp_addr) else begin
      n_err++;
      $error("FAIL %s write_address: got %0d expected %0d", tag, write_address, exp_addr);
    end

    obj_we   = 1'b0;
    swap_in  = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    rst_in = 1'b1;
    idle("reset", 3);
    rst_in = 1'b0;
    idle("post_reset", 2);

    // circle slot0 centre (100,100) r=10, static, swapped in
    set_obj(0, 1, 1, 100, 100, 10, 0);
    swap_in = 1'b1;
    tick("circ_load");
    set_px(110, 100); tick("circ_edge");
    set_px(111, 100); tick("circ_odd_drop");
    set_px(112, 100); tick("circ_out");
    set_px(100, 100); tick("circ_centre");
    idle("circ_drain", 3);

    // movable rect slot2 + static circle slot5 overlapping at (30,24)
    set_obj(2, 2, 0, 20, 20, 40, 30); tick("ovl_w2");
    set_obj(5, 1, 1, 30, 25, 5, 0);  swap_in = 1'b1; tick("ovl_w5");
    set_px(30, 24); tick("ovl_hit");
    set_px(30, 25); tick("ovl_odd");
    set_px(20, 20); tick("ovl_corner");
    set_px(40, 30); tick("ovl_far_corner");
    set_px(42, 30); tick("ovl_out");
    idle("ovl_drain", 3);

    // rect outline slot0 (10,10)-(20,20)
    set_obj(0, 3, 0, 10, 10, 20, 20); swap_in = 1'b1; tick("outl_load");
    set_px(14, 14); tick("outl_inner");
    set_px(15, 15); tick("outl_odd");
    set_px(10, 14); tick("outl_left");
    set_px(20, 20); tick("outl_corner");
    set_px(22, 14); tick("outl_out");
    idle("outl_drain", 3);

    // write slot1 + swap on the same cycle while streaming (50,50)
    for (int i = 0; i < 8; i++) begin
      set_px(50, 50);
      if (i == 3) begin
        set_obj(1, 2, 0, 40, 40, 60, 60);
        swap_in = 1'b1;
      end
      tick("stream_swap");
    end
    idle("stream_drain", 3);

    // scale grid: (3,4) dropped, (4,6) -> address 1922
    set_px(3, 4); tick("scale_drop");
    set_px(4, 6); tick("scale_addr");
    idle("scale_drain", 3);

    // reset with two pixels in flight
    set_px(50, 50); tick("flush_a");
    set_px(30, 24); tick("flush_b");
    rst_in = 1'b1; set_px(20, 20); tick("flush_rst");
    rst_in = 1'b0;
    idle("flush_after", 3);
    set_px(50, 50);   tick("empty_a");
    set_px(30, 24);   tick("empty_b");
    set_px(100, 100); swap_in = 1'b1; tick("empty_c");
    set_px(10, 14);   tick("empty_d");
    set_px(20, 20);   tick("empty_e");
    idle("empty_drain", 3);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int x1, y1;
        x1 = $urandom_range(0, 80);
        y1 = $urandom_range(0, 80);
        set_obj($urandom_range(0, NUM_OBJS - 1), $urandom_range(0, 3), $urandom_range(0, 1),
                x1, y1,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : x1 + $urandom_range(0, 40),
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, 30) : y1 + $urandom_range(0, 40));
      end
      if ($urandom_range(0, 9) == 0) swap_in = 1'b1;
      if ($urandom_range(0, 3) != 0) set_px($urandom_range(0, 100), $urandom_range(0, 100));
      rst_in = ($urandom_range(0, 149) == 0);
      tick("random");
    end
    rst_in = 1'b0;
    idle("final_drain", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
